// File: rtl/pccm_sync_collector.sv
// ============================================================================
// Module     : pccm_sync_collector
// Description: Collects per-core barrier-sync / halt pulses into stable levels
//              for the PCCM, turns continue levels into one-cycle resume
//              pulses, counts completed barriers. Optional barrier timeout
//              enabled by defining SYNC_TIMEOUT_EN.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module pccm_sync_collector #(
    parameter int                   NUM_CPU     = 4,
    parameter int                   CNT_W       = 16,
    parameter int                   TIMEOUT_W   = 16,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYC = 16'hFFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               int_reset,
    input  logic [NUM_CPU-1:0] cpu_sync_req,
    input  logic [NUM_CPU-1:0] cpu_halt_req,
    input  logic [NUM_CPU-1:0] cpu_continue_in,
    output logic [NUM_CPU-1:0] cpu_sync_out,
    output logic [NUM_CPU-1:0] cpu_halt_out,
    output logic [NUM_CPU-1:0] cpu_resume,
    output logic [CNT_W-1:0]   barrier_count,
    output logic               barrier_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARRIVED = 2'd1,
        ST_HALTED  = 2'd2
    } core_state_t;

    core_state_t        state_q [NUM_CPU];
    core_state_t        state_d [NUM_CPU];
    logic [NUM_CPU-1:0] resume_q, resume_d;
    logic [NUM_CPU-1:0] sync_out_q, sync_out_d;
    logic [NUM_CPU-1:0] halt_out_q, halt_out_d;
    logic [NUM_CPU-1:0] arrived_now;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               clear;

    assign clear = !reset || int_reset;

    always_comb begin
        for (int i = 0; i < NUM_CPU; i++) begin
            state_d[i]  = state_q[i];
            resume_d[i] = 1'b0;
            case (state_q[i])
                ST_HALTED: begin
                    state_d[i] = ST_HALTED;
                end
                ST_ARRIVED: begin
                    // Halt drops the pending arrival without a resume
                    if (cpu_halt_req[i]) begin
                        state_d[i] = ST_HALTED;
                    end else if (cpu_continue_in[i]) begin
                        resume_d[i] = 1'b1;
                        state_d[i]  = cpu_sync_req[i] ? ST_ARRIVED : ST_IDLE;
                    end
                end
                default: begin
                    if (cpu_halt_req[i]) begin
                        state_d[i] = ST_HALTED;
                    end else if (cpu_sync_req[i]) begin
                        state_d[i] = ST_ARRIVED;
                    end else begin
                        state_d[i] = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CPU; i++) begin
            arrived_now[i] = (state_q[i] == ST_ARRIVED);
            halt_out_d[i]  = (state_d[i] == ST_HALTED);
            sync_out_d[i]  = (state_d[i] == ST_ARRIVED) || (state_d[i] == ST_HALTED);
        end
    end

    // Any release while every core is synced completes a barrier
    always_comb begin
        count_d = count_q;
        if ((&sync_out_q) && (|resume_d)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < NUM_CPU; i++) begin
                state_q[i] <= ST_IDLE;
            end
            resume_q   <= '0;
            sync_out_q <= '0;
            halt_out_q <= '0;
            count_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_CPU; i++) begin
                state_q[i] <= state_d[i];
            end
            resume_q   <= resume_d;
            sync_out_q <= sync_out_d;
            halt_out_q <= halt_out_d;
            count_q    <= count_d;
        end
    end

`ifdef SYNC_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
    logic                 err_q, err_d;
    logic                 barrier_open;

    assign barrier_open = (|arrived_now) && !(&sync_out_q);

    always_comb begin
        tmo_d = '0;
        err_d = err_q || (tmo_q == TIMEOUT_CYC);
        if (barrier_open) begin
            tmo_d = (tmo_q == TIMEOUT_CYC) ? tmo_q : tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign barrier_err = err_q;
`else
    logic unused_arrived;
    assign unused_arrived = |arrived_now;
    assign barrier_err    = 1'b0;
`endif

    assign cpu_sync_out  = sync_out_q;
    assign cpu_halt_out  = halt_out_q;
    assign cpu_resume    = resume_q;
    assign barrier_count = count_q;

endmodule

`default_nettype wire
